ifu_mem_arb: RTL and testbench

Single-port memory arbiter sharing one 64-bit memory interface between the pipelined instruction fetch unit and the load/store unit. It sits between the IFU/LSU and the memory bridge and allows one outstanding transaction at a time. LSU has priority, with a bounded-streak guarantee for IFU. It discards in-flight fetch responses when the front end is redirected by a jump or flush.

---
 rtl/arb_pkg.sv | 19 +
 rtl/ifu_mem_arb.sv | 158 +++++++++++++++
 tb/tb_ifu_mem_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and widths for the IFU/LSU memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  localparam int MEM_AW  = 64;
  localparam int MEM_DW  = 64;
  localparam int INSTR_W = 32;

endpackage

// File: rtl/ifu_mem_arb.sv
// Single-outstanding arbiter sharing one 64-bit memory port between the
// instruction fetch unit and the load/store unit. LSU has priority, but a
// waiting fetch wins after LS_MAX consecutive LSU grants.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate; grant is combinational, command latched on grant
// REQ   | mem_req high, command held stable until mem_gnt
// RESP  | waiting for mem_rvalid; fetch response may be marked dropped
module ifu_mem_arb
  import arb_pkg::*;
#(
  parameter int LS_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rstn,

  input  logic                 if_req,
  input  logic [MEM_AW-1:0]    if_addr,
  input  logic                 if_flush,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [INSTR_W-1:0]   if_rdata,

  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [MEM_AW-1:0]    ls_addr,
  input  logic [MEM_DW-1:0]    ls_wdata,
  input  logic [MEM_DW/8-1:0]  ls_wmask,
  output logic                 ls_gnt,
  output logic                 ls_rvalid,
  output logic [MEM_DW-1:0]    ls_rdata,

  output logic                 mem_req,
  output logic                 mem_we,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic [MEM_DW-1:0]    mem_wdata,
  output logic [MEM_DW/8-1:0]  mem_wmask,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [MEM_DW-1:0]    mem_rdata
);

  localparam int SW = $clog2(LS_MAX + 1);

  arb_state_e    state;
  arb_owner_e    owner;
  logic          sel;
  logic          drop;
  logic [SW-1:0] streak;

  logic if_ok;
  logic streak_full;
  logic ls_win;
  logic if_win;
  logic if_kill;

  // Grant decision; no grant is offered while reset is asserted since
  // nothing would be latched.
  assign if_ok       = if_req & ~if_flush;
  assign streak_full = (streak == SW'(LS_MAX));
  assign ls_win      = rstn & (state == IDLE) & ls_req & ~(if_ok & streak_full);
  assign if_win      = rstn & (state == IDLE) & if_ok & ~ls_win;
  assign if_gnt      = if_win;
  assign ls_gnt      = ls_win;

  // A redirect while a fetch owns the port kills its response.
  assign if_kill = if_flush & (owner == OWN_IFU) & (state != IDLE);

  // Transaction FSM and latched memory command.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      owner     <= OWN_IFU;
      sel       <= 1'b0;
      drop      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ls_win) begin
            owner     <= OWN_LSU;
            mem_req   <= 1'b1;
            mem_we    <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            mem_wmask <= ls_wmask;
            state     <= REQ;
          end else if (if_win) begin
            owner     <= OWN_IFU;
            sel       <= if_addr[2];
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr & ~MEM_AW'(7);
            mem_wdata <= '0;
            mem_wmask <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (if_kill) drop <= 1'b1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= RESP;
          end
        end
        RESP: begin
          if (mem_rvalid) begin
            drop  <= 1'b0;
            state <= IDLE;
          end else if (if_kill) begin
            drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Count LSU wins over a waiting fetch; only updated while arbitrating.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      streak <= '0;
    end else if (state == IDLE) begin
      if (if_win || !if_req)
        streak <= '0;
      else if (ls_win && !streak_full)
        streak <= streak + SW'(1);
    end
  end

  // Route the memory response to its owner as a one-cycle pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if (state == RESP && mem_rvalid) begin
        if (owner == OWN_LSU) begin
          ls_rvalid <= 1'b1;
          ls_rdata  <= mem_rdata;
        end else if (!(drop || if_flush)) begin
          if_rvalid <= 1'b1;
          if_rdata  <= sel ? mem_rdata[MEM_DW-1:INSTR_W] : mem_rdata[INSTR_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_ifu_mem_arb.sv
// Bench for ifu_mem_arb: arbitration table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_ifu_mem_arb;

  localparam int LSM = 4;

  logic        clk;
  logic        rstn;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int n_tests = 0;
  int n_fail  = 0;

  ifu_mem_arb #(.LS_MAX(LSM)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 0; if_flush = 0; if_addr = 0;
    ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0; ls_wmask = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    nxt();
    nxt();
    rstn = 1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_mem_req"}, mem_req, 0);
    chk({nm, "_mem_we"}, mem_we, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_mem_wdata"}, mem_wdata, 0);
    chk({nm, "_mem_wmask"}, mem_wmask, 0);
    chk({nm, "_if_gnt"}, if_gnt, 0);
    chk({nm, "_ls_gnt"}, ls_gnt, 0);
    chk({nm, "_if_rvalid"}, if_rvalid, 0);
    chk({nm, "_ls_rvalid"}, ls_rvalid, 0);
    chk({nm, "_if_rdata"}, if_rdata, 0);
    chk({nm, "_ls_rdata"}, ls_rdata, 0);
  endtask

  typedef struct {
    logic ireq;
    logic iflush;
    logic lreq;
    logic e_if;
    logic e_ls;
  } vec_t;

  // Reference model state (transaction level)
  bit          m_busy, m_wait_gnt, m_lsu, m_sel, m_drop;
  int          m_streak;
  logic        m_we;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  bit          m_if_pulse, m_ls_pulse;
  logic [31:0] m_if_data;
  logic [63:0] m_ls_data;

  initial begin
    vec_t  vt[8];
    byte   order[10];
    int    ngr;
    string exp_ord;
    bit    e_if, e_ls, i_ok;

    do_reset();

    // ---------------- reset state
    rstn = 0;
    mid();
    chk_all_zero("reset");
    nxt();
    rstn = 1;

    // ---------------- arbitration table with streak at zero
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      if_req = vt[i].ireq; if_flush = vt[i].iflush; ls_req = vt[i].lreq;
      mid();
      chk($sformatf("table%0d_if_gnt", i), if_gnt, vt[i].e_if);
      chk($sformatf("table%0d_ls_gnt", i), ls_gnt, vt[i].e_ls);
      idle_inputs();
      nxt();
    end

    // ---------------- basic fetch, minimum latency
    if_req = 1; if_addr = 64'h8000_0004;
    mid();
    chk("fetch_gnt", if_gnt, 1);
    chk("fetch_ls_gnt", ls_gnt, 0);
    nxt(); if_req = 0; if_addr = 0; mem_gnt = 1;
    mid();
    chk("fetch_mem_req", mem_req, 1);
    chk("fetch_mem_addr", mem_addr, 64'h8000_0000);
    chk("fetch_mem_we", mem_we, 0);
    chk("fetch_mem_wmask", mem_wmask, 0);
    nxt(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h0000_0013_0000_0093;
    mid();
    chk("fetch_rvalid_c2", if_rvalid, 0);
    chk("fetch_mem_req_c2", mem_req, 0);
    nxt(); mem_rvalid = 0;
    mid();
    chk("fetch_rvalid_c3", if_rvalid, 1);
    chk("fetch_rdata", if_rdata, 64'h13);
    nxt();
    mid();
    chk("fetch_rvalid_c4", if_rvalid, 0);
    nxt();

    // ---------------- streak: both requesters held high
    if_req = 1; if_addr = 64'h8000_0010; ls_req = 1; ls_addr = 64'h40;
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 64'h55;
    ngr = 0;
    for (int c = 0; c < 60 && ngr < 10; c++) begin
      mid();
      if (if_gnt) begin order[ngr] = "I"; ngr++; end
      else if (ls_gnt) begin order[ngr] = "L"; ngr++; end
      nxt();
    end
    chk("streak_grant_count", ngr, 10);
    exp_ord = "LLLLILLLLI";
    for (int i = 0; i < 10 && i < ngr; i++)
      chk($sformatf("streak_order%0d", i), order[i], exp_ord[i]);
    if_req = 0; ls_req = 0;
    repeat (3) nxt();
    idle_inputs();
    repeat (2) nxt();

    // ---------------- store with delayed mem_gnt
    ls_req = 1; ls_we = 1; ls_addr = 64'h1000_0040; ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
    mid();
    chk("store_gnt", ls_gnt, 1);
    nxt();
    ls_req = 0; ls_we = 0; ls_addr = '1; ls_wdata = 64'h1234; ls_wmask = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      mem_gnt = (i == 3);
      mid();
      chk($sformatf("store_req%0d", i), mem_req, 1);
      chk($sformatf("store_we%0d", i), mem_we, 1);
      chk($sformatf("store_addr%0d", i), mem_addr, 64'h1000_0040);
      chk($sformatf("store_wdata%0d", i), mem_wdata, 64'hDEAD_BEEF);
      chk($sformatf("store_wmask%0d", i), mem_wmask, 8'h0F);
      nxt();
    end
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h0;
    mid();
    chk("store_resp_req", mem_req, 0);
    chk("store_rvalid_early", ls_rvalid, 0);
    nxt(); mem_rvalid = 0;
    mid();
    chk("store_rvalid", ls_rvalid, 1);
    nxt();
    mid();
    chk("store_rvalid_once", ls_rvalid, 0);
    idle_inputs();
    nxt();

    // ---------------- flush during RESP, late response, refetch
    if_req = 1; if_addr = 64'h8000_0200;
    mid();
    chk("flushresp_gnt", if_gnt, 1);
    nxt(); if_req = 0; mem_gnt = 1;
    mid();
    nxt(); mem_gnt = 0; if_flush = 1;
    mid();
    nxt(); if_flush = 0; if_req = 1; if_addr = 64'h8000_0100;
    for (int i = 0; i < 5; i++) begin
      mem_rvalid = (i == 4); mem_rdata = 64'hFFFF_0000_EEEE_1111;
      mid();
      chk($sformatf("flushresp_wait_gnt%0d", i), if_gnt, 0);
      nxt();
    end
    mem_rvalid = 0;
    mid();
    chk("flushresp_regnt", if_gnt, 1);
    chk("flushresp_dropped", if_rvalid, 0);
    nxt(); if_req = 0; mem_gnt = 1;
    mid();
    chk("refetch_addr", mem_addr, 64'h8000_0100);
    nxt(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'hAAAA_BBBB_1234_5678;
    mid();
    chk("refetch_no_early", if_rvalid, 0);
    nxt(); mem_rvalid = 0;
    mid();
    chk("refetch_rvalid", if_rvalid, 1);
    chk("refetch_rdata", if_rdata, 64'h1234_5678);
    nxt();

    // ---------------- flush in the same cycle as mem_rvalid
    if_req = 1; if_addr = 64'h8000_0104;
    mid();
    chk("flushsame_gnt", if_gnt, 1);
    nxt(); if_req = 0; mem_gnt = 1;
    mid();
    nxt(); mem_gnt = 0; mem_rvalid = 1; if_flush = 1; mem_rdata = 64'h1111_2222_3333_4444;
    mid();
    nxt(); mem_rvalid = 0; if_flush = 0;
    mid();
    chk("flushsame_drop", if_rvalid, 0);
    nxt();
    mid();
    chk("flushsame_drop2", if_rvalid, 0);
    nxt();

    // ---------------- reset during RESP
    if_req = 1; if_addr = 64'h8000_000C;
    mid();
    nxt(); if_req = 0; mem_gnt = 1;
    mid();
    nxt(); mem_gnt = 0;
    #2 rstn = 0;
    #1 chk_all_zero("async_reset");
    nxt();
    rstn = 1;
    nxt(); mem_rvalid = 1; mem_rdata = 64'h9999_8888_7777_6666;
    mid();
    nxt(); mem_rvalid = 0;
    mid();
    chk("late_rvalid_if", if_rvalid, 0);
    chk("late_rvalid_ls", ls_rvalid, 0);
    chk("late_mem_req", mem_req, 0);
    nxt();

    // ---------------- randomized run against reference model
    do_reset();
    m_busy = 0; m_wait_gnt = 0; m_lsu = 0; m_sel = 0; m_drop = 0; m_streak = 0;
    m_we = 0; m_addr = 0; m_wdata = 0; m_wmask = 0;
    m_if_pulse = 0; m_ls_pulse = 0; m_if_data = 0; m_ls_data = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if_req     = ($urandom_range(0, 2) != 0);
      if_flush   = ($urandom_range(0, 7) == 0);
      if_addr    = {$urandom, $urandom};
      ls_req     = ($urandom_range(0, 2) != 0);
      ls_we      = $urandom_range(0, 1);
      ls_addr    = {$urandom, $urandom};
      ls_wdata   = {$urandom, $urandom};
      ls_wmask   = 8'($urandom);
      mem_gnt    = $urandom_range(0, 1);
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = {$urandom, $urandom};
      mid();

      i_ok = if_req && !if_flush;
      e_ls = !m_busy && ls_req && !(i_ok && m_streak == LSM);
      e_if = !m_busy && i_ok && !e_ls;
      chk("rnd_if_gnt", if_gnt, e_if);
      chk("rnd_ls_gnt", ls_gnt, e_ls);
      chk("rnd_mem_req", mem_req, m_busy && m_wait_gnt);
      if (m_busy && m_wait_gnt) begin
        chk("rnd_mem_we", mem_we, m_we);
        chk("rnd_mem_addr", mem_addr, m_addr);
        chk("rnd_mem_wdata", mem_wdata, m_wdata);
        chk("rnd_mem_wmask", mem_wmask, m_wmask);
      end
      chk("rnd_if_rvalid", if_rvalid, m_if_pulse);
      chk("rnd_ls_rvalid", ls_rvalid, m_ls_pulse);
      if (m_if_pulse) chk("rnd_if_rdata", if_rdata, m_if_data);
      if (m_ls_pulse) chk("rnd_ls_rdata", ls_rdata, m_ls_data);

      m_if_pulse = 0;
      m_ls_pulse = 0;
      if (!m_busy) begin
        if (e_ls && if_req) m_streak = (m_streak + 1 > LSM) ? LSM : m_streak + 1;
        else if (e_if || !if_req) m_streak = 0;
        if (e_ls) begin
          m_busy = 1; m_wait_gnt = 1; m_lsu = 1; m_drop = 0;
          m_we = ls_we; m_addr = ls_addr; m_wdata = ls_wdata; m_wmask = ls_wmask;
        end else if (e_if) begin
          m_busy = 1; m_wait_gnt = 1; m_lsu = 0; m_drop = 0;
          m_sel = (if_addr % 8) >= 4;
          m_we = 0; m_addr = (if_addr / 8) * 8; m_wdata = 0; m_wmask = 0;
        end
      end else begin
        if (!m_lsu && if_flush) m_drop = 1;
        if (m_wait_gnt) begin
          if (mem_gnt) m_wait_gnt = 0;
        end else if (mem_rvalid) begin
          m_busy = 0;
          if (m_lsu) begin
            m_ls_pulse = 1; m_ls_data = mem_rdata;
          end else if (!m_drop) begin
            m_if_pulse = 1;
            m_if_data = m_sel ? 32'(mem_rdata / 64'h1_0000_0000) : 32'(mem_rdata % 64'h1_0000_0000);
          end
        end
      end
      nxt();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
